// File: rtl/drive_mode_ctrl_if.sv
// Switch/button inputs and command/indicator outputs of the driving
// controller, bundled for the board side (master) and controller (slave).
interface drive_mode_ctrl_if #(
  parameter int MILE_W = 16
);
  logic              power_on_signal;
  logic              power_off_signal;
  logic              manual_driving_signal;
  logic              throttle_signal;
  logic              clutch_signal;
  logic              brake_signal;
  logic              reverse_signal;
  logic              turn_left_signal;
  logic              turn_right_signal;
  logic              place_barrier_signal;
  logic              destroy_barrier_signal;
  logic [3:0]        state_o;
  logic              move_forward;
  logic              move_backward;
  logic              turn_left;
  logic              turn_right;
  logic              place_barrier;
  logic              destroy_barrier;
  logic [MILE_W-1:0] mileage;
  logic              left_turn_led;
  logic              right_turn_led;
  logic              reverse_led;

  modport master (
    output power_on_signal, power_off_signal,
    output manual_driving_signal,
    output throttle_signal, clutch_signal,
    output brake_signal, reverse_signal,
    output turn_left_signal, turn_right_signal,
    output place_barrier_signal,
    output destroy_barrier_signal,
    input  state_o, move_forward, move_backward,
    input  turn_left, turn_right,
    input  place_barrier, destroy_barrier,
    input  mileage, left_turn_led,
    input  right_turn_led, reverse_led
  );

  modport slave (
    input  power_on_signal, power_off_signal,
    input  manual_driving_signal,
    input  throttle_signal, clutch_signal,
    input  brake_signal, reverse_signal,
    input  turn_left_signal, turn_right_signal,
    input  place_barrier_signal,
    input  destroy_barrier_signal,
    output state_o, move_forward, move_backward,
    output turn_left, turn_right,
    output place_barrier, destroy_barrier,
    output mileage, left_turn_led,
    output right_turn_led, reverse_led
  );
endinterface

// File: rtl/drive_mode_ctrl.sv
// Manual-driving state machine with power-on hold, mileage and blinkers.
// Optional idle auto power-off: define AUTO_POWER_OFF_EN.
module drive_mode_ctrl #(
  parameter int PON_CYCLES   = 100000000,
  parameter int TICK_CYCLES  = 10000000,
  parameter int MILE_W       = 16,
  parameter int BLINK_CYCLES = 25000000,
  parameter int IDLE_CYCLES  = 500000000
) (
  input logic              sys_clk,
  input logic              rst,
  drive_mode_ctrl_if.slave bus
);

  localparam int PW = $clog2(PON_CYCLES + 1);
  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);

  typedef enum logic [3:0] {
    S_OFF = 4'd0,
    S_ON  = 4'd1,
    S_NS  = 4'd2,
    S_ST  = 4'd3,
    S_MV  = 4'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [PW-1:0]     r_pon;
  logic [TW-1:0]     r_tick;
  logic [MILE_W-1:0] r_mile;
  logic [BW-1:0]     r_blink;
  logic              r_phase;
  logic              r_rev;
  logic              r_fwd;
  logic              r_bwd;
  logic              r_tl;
  logic              r_tr;
  logic              r_pb;
  logic              r_db;

  logic w_t;
  logic w_b;
  logic w_c;
  logic w_rev_chg;
  logic w_pon_hit;
  logic w_to_off;
  logic w_turn_any;
  logic w_idle_hit;

  assign w_t        = bus.throttle_signal;
  assign w_b        = bus.brake_signal;
  assign w_c        = bus.clutch_signal;
  assign w_rev_chg  = bus.reverse_signal ^ r_rev;
  assign w_turn_any = bus.turn_left_signal
                    | bus.turn_right_signal;
  assign w_pon_hit  = bus.power_on_signal
                    && (r_pon == PW'(PON_CYCLES - 1));
  assign w_to_off   = (r_state != S_OFF)
                    && (w_next == S_OFF);

`ifdef AUTO_POWER_OFF_EN
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  logic [IW-1:0] r_idle;
  logic          w_idle_st;
  logic          w_idle_act;

  assign w_idle_st  = (r_state == S_ON)
                    || (r_state == S_NS);
  assign w_idle_act = bus.manual_driving_signal
                    | w_t | w_b | w_c;
  assign w_idle_hit = w_idle_st && !w_idle_act
                    && (r_idle == IW'(IDLE_CYCLES - 1));

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_idle <= '0;
    end else if (!w_idle_st || w_idle_act
                 || (w_next != r_state)) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + IW'(1);
    end
  end
`else
  assign w_idle_hit = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_OFF: begin
        if (w_pon_hit) w_next = S_ON;
      end
      S_ON: begin
        if (bus.manual_driving_signal) w_next = S_NS;
      end
      S_NS: begin
        if (w_t && !w_c)            w_next = S_OFF;
        else if (w_t && !w_b && w_c) w_next = S_ST;
      end
      S_ST: begin
        if (w_b)              w_next = S_NS;
        else if (w_t && !w_c) w_next = S_MV;
      end
      S_MV: begin
        if (w_rev_chg && !w_c) w_next = S_OFF;
        else if (w_b)          w_next = S_NS;
        else if (!w_t || w_c)  w_next = S_ST;
      end
      default: w_next = S_OFF;
    endcase
    // power-off button outranks every other exit
    if ((r_state != S_OFF)
        && (bus.power_off_signal || w_idle_hit))
      w_next = S_OFF;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_OFF;
      r_rev   <= 1'b0;
      r_pon   <= '0;
    end else begin
      r_state <= w_next;
      r_rev   <= bus.reverse_signal;
      if ((r_state == S_OFF) && (w_next == S_OFF)
          && bus.power_on_signal)
        r_pon <= r_pon + PW'(1);
      else
        r_pon <= '0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_fwd <= 1'b0;
      r_bwd <= 1'b0;
      r_tl  <= 1'b0;
      r_tr  <= 1'b0;
      r_pb  <= 1'b0;
      r_db  <= 1'b0;
    end else if (r_state == S_MV) begin
      r_fwd <= ~bus.reverse_signal;
      r_bwd <= bus.reverse_signal;
      r_tl  <= bus.turn_left_signal;
      r_tr  <= bus.turn_right_signal;
      r_pb  <= bus.place_barrier_signal;
      r_db  <= bus.destroy_barrier_signal;
    end else begin
      r_fwd <= 1'b0;
      r_bwd <= 1'b0;
      r_tl  <= 1'b0;
      r_tr  <= 1'b0;
      r_pb  <= 1'b0;
      r_db  <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_tick <= '0;
      r_mile <= '0;
    end else if (w_to_off) begin
      r_tick <= '0;
      r_mile <= '0;
    end else if (r_state == S_MV) begin
      if (r_tick == TW'(TICK_CYCLES - 1)) begin
        r_tick <= '0;
        if (r_mile != {MILE_W{1'b1}})
          r_mile <= r_mile + MILE_W'(1);
      end else begin
        r_tick <= r_tick + TW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_blink <= '0;
      r_phase <= 1'b0;
    end else if (!w_turn_any) begin
      r_blink <= '0;
      r_phase <= 1'b0;
    end else if (r_blink == BW'(BLINK_CYCLES - 1)) begin
      r_blink <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_blink <= r_blink + BW'(1);
    end
  end

  assign bus.state_o         = r_state;
  assign bus.move_forward    = r_fwd;
  assign bus.move_backward   = r_bwd;
  assign bus.turn_left       = r_tl;
  assign bus.turn_right      = r_tr;
  assign bus.place_barrier   = r_pb;
  assign bus.destroy_barrier = r_db;
  assign bus.mileage         = r_mile;
  assign bus.reverse_led     = r_rev;
  assign bus.left_turn_led   = bus.turn_left_signal
                             & ~r_phase;
  assign bus.right_turn_led  = bus.turn_right_signal
                             & ~r_phase;

endmodule

// File: tb/tb_drive_mode_ctrl.sv
// Randomised + directed bench for drive_mode_ctrl against
// a cycle-level behavioural model.
module tb_drive_mode_ctrl;

  localparam int PON   = 4;
  localparam int TICK  = 3;
  localparam int BLINK = 2;
  localparam int MW    = 3;
  localparam int IDLE  = 5;
  localparam int MAXM  = (1 << MW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  drive_mode_ctrl_if #(.MILE_W(MW)) dif ();

  drive_mode_ctrl #(
    .PON_CYCLES  (PON),
    .TICK_CYCLES (TICK),
    .MILE_W      (MW),
    .BLINK_CYCLES(BLINK),
    .IDLE_CYCLES (IDLE)
  ) u_dut (
    .sys_clk(clk),
    .rst    (rst_n),
    .bus    (dif.slave)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // model state: plain integers, counted from the rules
  int m_st;
  int m_pon;
  int m_mov;
  int m_el;
  int m_idle;
  bit m_rev;
  bit [5:0] m_mot;

  task automatic m_reset();
    m_st = 0; m_pon = 0; m_mov = 0;
    m_el = 0; m_idle = 0; m_rev = 0;
    m_mot = '0;
  endtask

  task automatic setin(input bit pon, input bit poff,
                       input bit man, input bit t,
                       input bit c, input bit b,
                       input bit rev, input bit tl,
                       input bit tr);
    dif.power_on_signal       = pon;
    dif.power_off_signal      = poff;
    dif.manual_driving_signal = man;
    dif.throttle_signal       = t;
    dif.clutch_signal         = c;
    dif.brake_signal          = b;
    dif.reverse_signal        = rev;
    dif.turn_left_signal      = tl;
    dif.turn_right_signal     = tr;
  endtask

  task automatic m_step();
    bit pon, poff, man, t, c, b, rev, tl, tr, rc, act;
    int nx;
    pon  = dif.power_on_signal;
    poff = dif.power_off_signal;
    man  = dif.manual_driving_signal;
    t    = dif.throttle_signal;
    c    = dif.clutch_signal;
    b    = dif.brake_signal;
    rev  = dif.reverse_signal;
    tl   = dif.turn_left_signal;
    tr   = dif.turn_right_signal;
    rc   = (rev != m_rev);
    act  = man | t | b | c;
    nx   = m_st;
    case (m_st)
      0: nx = (pon && (m_pon + 1 >= PON)) ? 1 : 0;
      1: if (man) nx = 2;
      2: if (t && !c) nx = 0;
         else if (t && !b && c) nx = 3;
      3: if (b) nx = 2;
         else if (t && !c) nx = 4;
      4: if (rc && !c) nx = 0;
         else if (b) nx = 2;
         else if (!t || c) nx = 3;
      default: nx = 0;
    endcase
`ifdef AUTO_POWER_OFF_EN
    if ((m_st == 1 || m_st == 2) && !act
        && (m_idle + 1 >= IDLE)) nx = 0;
`endif
    if (m_st != 0 && poff) nx = 0;
    m_pon = (m_st == 0 && nx == 0 && pon)
          ? m_pon + 1 : 0;
    if (m_st == 4)
      m_mot = {~rev, rev, tl, tr,
               dif.place_barrier_signal,
               dif.destroy_barrier_signal};
    else
      m_mot = '0;
    if (m_st == 4) m_mov++;
    if (m_st != 0 && nx == 0) m_mov = 0;
    m_el = (tl | tr) ? m_el + 1 : 0;
    m_idle = ((m_st == 1 || m_st == 2) && !act
              && nx == m_st) ? m_idle + 1 : 0;
    m_rev = rev;
    m_st = nx;
  endtask

  task automatic check_all();
    int mi;
    bit ph;
    mi = m_mov / TICK;
    if (mi > MAXM) mi = MAXM;
    ph = ((m_el / BLINK) % 2) != 0;
    chk("state", dif.state_o, m_st);
    chk("motion", {dif.move_forward, dif.move_backward,
                   dif.turn_left, dif.turn_right,
                   dif.place_barrier,
                   dif.destroy_barrier}, m_mot);
    chk("mileage", dif.mileage, mi);
    chk("led_l", dif.left_turn_led,
        dif.turn_left_signal & ~ph);
    chk("led_r", dif.right_turn_led,
        dif.turn_right_signal & ~ph);
    chk("rev_led", dif.reverse_led, m_rev);
  endtask

  task automatic step();
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic go_moving(input bit rev);
    setin(1, 0, 0, 0, 0, 0, rev, 0, 0);
    steps(PON);
    chk("go_on", dif.state_o, 1);
    setin(0, 0, 1, 0, 0, 0, rev, 0, 0);
    step();
    chk("go_ns", dif.state_o, 2);
    setin(0, 0, 0, 1, 1, 0, rev, 0, 0);
    step();
    chk("go_st", dif.state_o, 3);
    setin(0, 0, 0, 1, 0, 0, rev, 0, 0);
    step();
    chk("go_mv", dif.state_o, 4);
  endtask

  initial begin
    bit pv [6];
    m_reset();
    dif.place_barrier_signal   = 1'b0;
    dif.destroy_barrier_signal = 1'b0;
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check_all();
    chk("rst_state", dif.state_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    setin(1, 0, 0, 0, 0, 0, 0, 0, 0);
    steps(3);
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("pon_short", dif.state_o, 0);
    setin(1, 0, 0, 0, 0, 0, 0, 0, 0);
    steps(2);
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    setin(1, 0, 0, 0, 0, 0, 0, 0, 0);
    steps(3);
    chk("pon_gap", dif.state_o, 0);
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    go_moving(0);
    step();
    chk("fwd", dif.move_forward, 1);
    setin(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step();
    chk("brake_ns", dif.state_o, 2);
    setin(0, 0, 0, 1, 0, 0, 0, 0, 0);
    step();
    chk("stall", dif.state_o, 0);

    go_moving(1);
    step();
    chk("bwd", dif.move_backward, 1);
    setin(0, 0, 0, 1, 1, 0, 0, 0, 0);
    step();
    chk("rev_clutch", dif.state_o, 3);
    setin(0, 0, 0, 1, 0, 0, 0, 0, 0);
    steps(5);
    setin(0, 0, 0, 1, 0, 0, 1, 0, 0);
    step();
    chk("rev_fault", dif.state_o, 0);
    chk("rev_mile0", dif.mileage, 0);

    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    go_moving(0);
    steps(9);
    chk("mile9", dif.mileage, 3);
    setin(0, 0, 0, 1, 1, 0, 0, 0, 0);
    steps(5);
    chk("mile_hold", dif.mileage, 3);
    setin(0, 0, 0, 1, 0, 0, 0, 0, 0);
    step();
    steps(30);
    chk("mile_sat", dif.mileage, MAXM);

    setin(0, 1, 0, 1, 0, 1, 0, 0, 0);
    step();
    chk("poff", dif.state_o, 0);

    pv = '{1, 0, 0, 1, 1, 0};
    setin(0, 0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("blink0", dif.left_turn_led, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("blink", dif.left_turn_led, pv[i]);
    end
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("blink_off", dif.left_turn_led, 0);
    step();

`ifdef AUTO_POWER_OFF_EN
    setin(1, 0, 0, 0, 0, 0, 0, 0, 0);
    steps(PON);
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    steps(IDLE - 1);
    chk("idle_on", dif.state_o, 1);
    step();
    chk("idle_off", dif.state_o, 0);
    setin(1, 0, 0, 0, 0, 0, 0, 0, 0);
    steps(PON);
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    steps(2);
    setin(0, 0, 1, 0, 0, 0, 0, 0, 0);
    step();
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    steps(IDLE - 1);
    chk("idle_rst", dif.state_o, 2);
    step();
    chk("idle_ns", dif.state_o, 0);
`else
    setin(1, 0, 0, 0, 0, 0, 0, 0, 0);
    steps(PON);
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    steps(3 * IDLE);
    chk("no_idle", dif.state_o, 1);
    setin(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step();
`endif

    for (int i = 0; i < 3000; i++) begin
      bit rv;
      rv = dif.reverse_signal;
      if ($urandom_range(9) == 0) rv = ~rv;
      setin($urandom_range(9) < 7,
            $urandom_range(39) == 0,
            $urandom_range(1) != 0,
            $urandom_range(3) != 0,
            $urandom_range(2) == 0,
            $urandom_range(4) == 0,
            rv,
            $urandom_range(3) != 0,
            $urandom_range(3) == 0);
      dif.place_barrier_signal   = $urandom_range(1) != 0;
      dif.destroy_barrier_signal = $urandom_range(1) != 0;
      step();
    end

    dif.place_barrier_signal   = 1'b0;
    dif.destroy_barrier_signal = 1'b0;
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    go_moving(0);
    steps(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", dif.state_o, 0);
    chk("arst_fwd", dif.move_forward, 0);
    chk("arst_mile", dif.mileage, 0);
    m_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    steps(2);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
